// File: rtl/alu_z_buffer_if.sv
// Handshake and head-entry bus between the ALU result producer, the Z buffer and the datapath consumer.
interface alu_z_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_lo;
  logic [DATA_WIDTH-1:0] in_hi;
  logic                  in_wide;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ZLow;
  logic [DATA_WIDTH-1:0] ZHigh;
  logic [CNT_WIDTH-1:0]  count;
  logic                  z_zero;
  logic                  z_neg;

  modport master (
    output in_valid, in_lo, in_hi, in_wide, out_ready,
    input  in_ready, out_valid, ZLow, ZHigh, count, z_zero, z_neg
  );

  modport slave (
    input  in_valid, in_lo, in_hi, in_wide, out_ready,
    output in_ready, out_valid, ZLow, ZHigh, count, z_zero, z_neg
  );
endinterface

// File: rtl/alu_z_buffer.sv
// Small FIFO of Z-register entries (ZLow/ZHigh) between the ALU units and bus write-back.
// Define ALU_Z_FLAGS_EN to store per-entry zero/sign flags; otherwise z_zero/z_neg are tied to 0.
module alu_z_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 2
) (
  input logic            clk,
  input logic            clr,
  alu_z_buffer_if.slave  zb
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] lo_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] hi_q;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] hi_in;

  // Readiness comes from registered occupancy only, so a full buffer never takes a push even while popping.
  assign zb.in_ready  = (count_reg != CNT_WIDTH'(DEPTH));
  assign zb.out_valid = (count_reg != '0);
  assign zb.count     = count_reg;

  assign push  = zb.in_valid && zb.in_ready;
  assign pop   = zb.out_valid && zb.out_ready;
  assign hi_in = zb.in_wide ? zb.in_hi : '0;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_WIDTH'(1);
      2'b01:   count_next = count_reg - CNT_WIDTH'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entries are discrete registers so clr can wipe them asynchronously and the head reads combinationally.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] lo_reg;
      logic [DATA_WIDTH-1:0] hi_reg;

      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          lo_reg <= '0;
          hi_reg <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          lo_reg <= zb.in_lo;
          hi_reg <= hi_in;
        end
      end

      assign lo_q[gi] = lo_reg;
      assign hi_q[gi] = hi_reg;
    end
  endgenerate

  assign zb.ZLow  = zb.out_valid ? lo_q[rd_ptr_reg] : '0;
  assign zb.ZHigh = zb.out_valid ? hi_q[rd_ptr_reg] : '0;

`ifdef ALU_Z_FLAGS_EN
  logic [DEPTH-1:0] zero_q;
  logic [DEPTH-1:0] neg_q;
  logic             zero_in;
  logic             neg_in;

  assign zero_in = ({hi_in, zb.in_lo} == '0);
  assign neg_in  = zb.in_wide ? zb.in_hi[DATA_WIDTH-1] : zb.in_lo[DATA_WIDTH-1];

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flags
      logic zero_reg;
      logic neg_reg;

      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          zero_reg <= 1'b0;
          neg_reg  <= 1'b0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          zero_reg <= zero_in;
          neg_reg  <= neg_in;
        end
      end

      assign zero_q[gi] = zero_reg;
      assign neg_q[gi]  = neg_reg;
    end
  endgenerate

  assign zb.z_zero = zb.out_valid && zero_q[rd_ptr_reg];
  assign zb.z_neg  = zb.out_valid && neg_q[rd_ptr_reg];
`else
  assign zb.z_zero = 1'b0;
  assign zb.z_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_z_buffer.sv
// Directed bench for alu_z_buffer: reset, capture, backpressure, full-with-pop, streaming and flag cases.
module tb_alu_z_buffer;
  localparam int DW = 32;
  localparam int CW = 2;
`ifdef ALU_Z_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk;
  logic clr;
  int   checks;
  int   errors;
  int   cyc;

  alu_z_buffer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) zb ();

  alu_z_buffer #(.DATA_WIDTH(DW), .DEPTH(2), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .clr (clr),
    .zb  (zb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".in_ready"},  64'(zb.in_ready),  64'd1);
    check({tag, ".out_valid"}, 64'(zb.out_valid), 64'd0);
    check({tag, ".count"},     64'(zb.count),     64'd0);
    check({tag, ".ZLow"},      64'(zb.ZLow),      64'd0);
    check({tag, ".ZHigh"},     64'(zb.ZHigh),     64'd0);
    check({tag, ".z_zero"},    64'(zb.z_zero),    64'd0);
    check({tag, ".z_neg"},     64'(zb.z_neg),     64'd0);
  endtask

  // One clock edge, then sample 1 time unit later; one line per transaction.
  task automatic step();
    logic p, q;
    p = zb.in_valid && zb.in_ready;
    q = zb.out_valid && zb.out_ready;
    @(posedge clk);
    #1;
    cyc++;
    $display("cycle %0d push=%0b pop=%0b count=%0d ZHigh=%08h ZLow=%08h flags z=%0b n=%0b",
             cyc, p, q, zb.count, zb.ZHigh, zb.ZLow, zb.z_zero, zb.z_neg);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    clr          = 1'b1;
    zb.in_valid  = 1'b0;
    zb.in_lo     = '0;
    zb.in_hi     = '0;
    zb.in_wide   = 1'b0;
    zb.out_ready = 1'b0;

    // Reset held for two cycles
    step();
    check_empty("rst_hold1");
    step();
    check_empty("rst_hold2");
    #2 clr = 1'b0;

    // Push one entry, then clear asynchronously between edges
    zb.in_valid = 1'b1;
    zb.in_lo    = 32'hA5A5A5A5;
    step();
    zb.in_valid = 1'b0;
    check("pre_async.count", 64'(zb.count), 64'd1);
    #3 clr = 1'b1;
    #1 check_empty("rst_async");
    #1 clr = 1'b0;

    // Single shra capture; in_hi must be ignored since in_wide=0
    zb.in_valid  = 1'b1;
    zb.in_lo     = 32'hF8000000;
    zb.in_hi     = 32'hDEADBEEF;
    zb.in_wide   = 1'b0;
    zb.out_ready = 1'b0;
    step();
    zb.in_valid = 1'b0;
    check("shra.out_valid", 64'(zb.out_valid), 64'd1);
    check("shra.ZLow",      64'(zb.ZLow),      64'hF8000000);
    check("shra.ZHigh",     64'(zb.ZHigh),     64'd0);
    check("shra.count",     64'(zb.count),     64'd1);
    check("shra.z_neg",     64'(zb.z_neg),     FLAGS ? 64'd1 : 64'd0);
    check("shra.z_zero",    64'(zb.z_zero),    64'd0);
    zb.out_ready = 1'b1;
    step();
    zb.out_ready = 1'b0;
    check_empty("shra_drain");

    // Fill and backpressure
    zb.in_valid = 1'b1;
    zb.in_lo    = 32'h11111111;
    step();
    zb.in_lo    = 32'h22222222;
    step();
    check("fill.count",    64'(zb.count),    64'd2);
    check("fill.in_ready", 64'(zb.in_ready), 64'd0);
    check("fill.head",     64'(zb.ZLow),     64'h11111111);
    zb.in_lo    = 32'h33333333;
    step();
    step();
    check("bp.count",    64'(zb.count),    64'd2);
    check("bp.in_ready", 64'(zb.in_ready), 64'd0);
    check("bp.head",     64'(zb.ZLow),     64'h11111111);

    // Full with same-cycle pop: input still refused
    zb.out_ready = 1'b1;
    step();
    zb.in_valid = 1'b0;
    check("fullpop.count",    64'(zb.count),    64'd1);
    check("fullpop.head",     64'(zb.ZLow),     64'h22222222);
    check("fullpop.in_ready", 64'(zb.in_ready), 64'd1);
    step();
    check_empty("fullpop_drain");

    // Streaming 1..8 with the consumer always ready
    for (int i = 1; i <= 8; i++) begin
      zb.in_valid = 1'b1;
      zb.in_lo    = 32'(i);
      step();
      check($sformatf("stream%0d.count", i), 64'(zb.count), 64'd1);
      check($sformatf("stream%0d.head", i),  64'(zb.ZLow),  64'(i));
    end
    zb.in_valid = 1'b0;
    step();
    check_empty("stream_drain");

    // Wide results exercising zero and sign flags
    zb.out_ready = 1'b0;
    zb.in_valid  = 1'b1;
    zb.in_wide   = 1'b1;
    zb.in_hi     = 32'h00000000;
    zb.in_lo     = 32'h00000000;
    step();
    check("wide0.z_zero", 64'(zb.z_zero), FLAGS ? 64'd1 : 64'd0);
    check("wide0.z_neg",  64'(zb.z_neg),  64'd0);
    check("wide0.ZHigh",  64'(zb.ZHigh),  64'd0);
    zb.in_hi = 32'h80000000;
    zb.in_lo = 32'h00000000;
    step();
    zb.in_valid = 1'b0;
    zb.in_wide  = 1'b0;
    check("wide.count", 64'(zb.count), 64'd2);
    zb.out_ready = 1'b1;
    step();
    check("wide1.ZHigh",  64'(zb.ZHigh),  64'h80000000);
    check("wide1.ZLow",   64'(zb.ZLow),   64'd0);
    check("wide1.z_zero", 64'(zb.z_zero), 64'd0);
    check("wide1.z_neg",  64'(zb.z_neg),  FLAGS ? 64'd1 : 64'd0);
    step();
    check_empty("wide_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_z_buffer.md
Name: alu_z_buffer

Overview:
- Registered result stage directly downstream of the combinational ALU units (shra, shl, add, mul, etc.).
- Captures the selected ALU result into a small FIFO of Z-register entries (ZLow/ZHigh) using a valid/ready handshake.
- Presents the oldest entry to the datapath bus side.
- Decouples single-cycle ALU outputs from bus write-back timing so back-to-back ALU ops are never lost while the bus is busy.

Parameters:
- DATA_WIDTH, 32, width of each half of Z (ZLow and ZHigh).
- DEPTH, 2, number of buffered entries. Must be a power of two, at least 2.
- CNT_WIDTH, 2, width of the occupancy count. Must satisfy 2**CNT_WIDTH > DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-high reset.
- in_valid  input  1  ALU result on in_lo/in_hi is valid this cycle.
- in_ready  output  1  buffer can accept an entry this cycle.
- in_lo  input  DATA_WIDTH  low result word, e.g. the shra Z output.
- in_hi  input  DATA_WIDTH  high result word (mul/div upper half).
- in_wide  input  1  1 = capture in_hi; 0 = store 0 into ZHigh.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes the head entry this cycle.
- ZLow  output  DATA_WIDTH  head entry low word.
- ZHigh  output  DATA_WIDTH  head entry high word.
- count  output  CNT_WIDTH  current occupancy, 0..DEPTH.
- z_zero  output  1  head flag: 64-bit result == 0 (see Optional Feature).
- z_neg  output  1  head flag: sign bit of the result (see Optional Feature).

Behaviour:
- Reset: clk is the single clock; clr is asynchronous and active-high.
  - While clr=1: write pointer, read pointer and count are 0; all storage entries are 0.
  - Resulting output values: in_ready=1, out_valid=0, ZLow=ZHigh=0, z_zero=z_neg=0.
  - clr asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Push:
  - Occurs on a rising edge where in_valid && in_ready.
  - Writes {hi, in_lo} to entry[wr_ptr], where hi = in_wide ? in_hi : 0.
  - wr_ptr increments, wrapping modulo DEPTH.
- Pop:
  - Occurs on a rising edge where out_valid && out_ready.
  - rd_ptr increments, wrapping modulo DEPTH.
- in_ready = (count != DEPTH).
  - Depends only on registered count, never on out_ready; there is no combinational pass-through.
  - When full, a same-cycle pop does not allow a push.
- out_valid = (count != 0).
- ZLow/ZHigh:
  - Driven combinationally from entry[rd_ptr] when out_valid=1.
  - Forced to 0 when empty.
- Latency: an entry pushed at edge N is visible on ZLow/ZHigh with out_valid=1 after edge N, i.e. one cycle.
- Count update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, data order preserved.
  - neither: unchanged.
- Empty with push and no pop: count becomes 1.
  - Pop is impossible when empty because out_valid=0.
  - out_ready while empty has no effect.
- Full with in_valid=1: no capture and in_valid ignored.
  - The producer must hold its data; the upstream ALU operands stay stable.
- Ordering: strict FIFO. Entries never reorder, duplicate or drop.
- Input fields are sampled only on a push edge and are don't-care otherwise.

Optional Feature:
- Macro: ALU_Z_FLAGS_EN.
- Defined:
  - Each entry stores two extra bits computed at push time:
    - zero = ({hi, in_lo} == 0).
    - neg = in_wide ? in_hi[DATA_WIDTH-1] : in_lo[DATA_WIDTH-1].
  - z_zero/z_neg present the head entry's flags when out_valid=1, and are 0 when empty.
- Undefined:
  - No flag storage is built.
  - z_zero and z_neg are tied to 0 at all times.
  - The ports remain present.

Test Plan:
- Reset: hold clr=1 for 2 cycles, deassert, then assert clr asynchronously between edges while count=1.
  - Required: in_ready=1, out_valid=0, count=0 and ZLow=ZHigh=0 in all three cases, immediately after each clr assertion.
- Single shra capture: push in_lo=0xF8000000 (shra of 0x80000000 by 4), in_wide=0, out_ready=0.
  - Next cycle required: out_valid=1, ZLow=0xF8000000, ZHigh=0, count=1.
  - With flags: z_neg=1, z_zero=0.
- Fill and backpressure (DEPTH=2): push 0x11111111 then 0x22222222 with out_ready=0, then hold in_valid=1 with 0x33333333.
  - Required: count=2, in_ready=0, and 0x33333333 is never captured.
- Full with same-cycle pop: at count=2, in_valid=1 and out_ready=1 for one edge.
  - Required: count=1, head becomes 0x22222222, and the input is not taken.
- Streaming: push 8 consecutive values 1..8 with out_ready=1 throughout.
  - Required: count stays 1 after the first edge; consumer sees 1..8 in order; pointers wrap with no loss.
- Wide result with zero flag: push in_wide=1, in_hi=0, in_lo=0, then in_wide=1, in_hi=0x80000000, in_lo=0.
  - Required with ALU_Z_FLAGS_EN: first entry z_zero=1, z_neg=0; second entry z_zero=0, z_neg=1, ZHigh=0x80000000.
  - Required without the macro: both flags read 0.
